// File: rtl/imuldiv_muldiv_frontend.sv
// imuldiv_muldiv_frontend: decodes processor mul/div ops, issues them to the iterative unit and returns in-order writebacks
// ports: req_* processor request (val/rdy), muldivreq_* unit request, muldivresp_* unit response,
//        wb_* registered writeback (val/rdy), outstanding = tracking FIFO occupancy
module imuldiv_muldiv_frontend #(
   parameter int TRACK_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_val,
   output logic                          req_rdy,
   input  logic [2:0]                    req_op,
   input  logic [31:0]                   req_a,
   input  logic [31:0]                   req_b,
   input  logic [4:0]                    req_dest,
   output logic [2:0]                    muldivreq_msg_fn,
   output logic [31:0]                   muldivreq_msg_a,
   output logic [31:0]                   muldivreq_msg_b,
   output logic                          muldivreq_val,
   input  logic                          muldivreq_rdy,
   input  logic [63:0]                   muldivresp_msg_result,
   input  logic                          muldivresp_val,
   output logic                          muldivresp_rdy,
   output logic                          wb_val,
   input  logic                          wb_rdy,
   output logic [31:0]                   wb_data,
   output logic [4:0]                    wb_dest,
   output logic [$clog2(TRACK_DEPTH):0]  outstanding
);
   localparam int AW = $clog2(TRACK_DEPTH);
   localparam int CW = AW + 1;
   // entry layout: {hi_sel, bypass, dest}
   logic [6:0]    track [TRACK_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [6:0]    head;
   logic          bypass, full, empty, req_fire, out_free, resp_fire, byp_pop, pop, direct, push, load;
   logic [31:0]   load_data;
   logic [4:0]    load_dest;
   always_comb begin
      bypass           = req_op > 3'd5;
      muldivreq_msg_fn = req_op < 3'd2 ? 3'd0 : req_op < 3'd4 ? 3'd1 : 3'd2;
      muldivreq_msg_a  = req_a;
      muldivreq_msg_b  = req_b;
      full             = outstanding == CW'(TRACK_DEPTH);
      empty            = outstanding == '0;
      head             = track[rd_ptr];
      out_free         = !wb_val || wb_rdy;
      req_rdy          = !reset && !full && (bypass || muldivreq_rdy);
      muldivreq_val    = !reset && req_val && !full && !bypass;
      req_fire         = req_val && req_rdy;
      muldivresp_rdy   = !reset && !empty && !head[5] && out_free;
      resp_fire        = muldivresp_val && muldivresp_rdy;
      byp_pop          = !empty && head[5] && out_free;
      pop              = resp_fire || byp_pop;
      // an illegal op arriving at an empty FIFO skips the FIFO so its writeback appears the next cycle
      direct           = req_fire && bypass && empty && out_free;
      push             = req_fire && !direct;
      load             = pop || direct;
      load_data        = resp_fire ? (head[6] ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0]) : 32'd0;
      load_dest        = empty ? req_dest : head[4:0];
   end
   always_ff @(posedge clk)
      if (push) track[wr_ptr] <= {req_op[0], bypass, req_dest};
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         outstanding <= '0;
         wb_val      <= 1'b0;
         wb_data     <= '0;
         wb_dest     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         outstanding <= outstanding + CW'(push) - CW'(pop);
         if (load) begin
            wb_val  <= 1'b1;
            wb_data <= load_data;
            wb_dest <= load_dest;
         end else if (wb_rdy) begin
            wb_val  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_imuldiv_muldiv_frontend.sv
// tb_imuldiv_muldiv_frontend: directed bench with a pipelined mul/div unit model and writeback capture
module tb_imuldiv_muldiv_frontend;
   localparam int LAT = 6;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_val, req_rdy;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_dest;
   logic [2:0]  muldivreq_msg_fn;
   logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
   logic        muldivreq_val, muldivreq_rdy;
   logic [63:0] muldivresp_msg_result;
   logic        muldivresp_val, muldivresp_rdy;
   logic        wb_val, wb_rdy;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic [1:0]  outstanding;
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [63:0] u_res [8];
   int          u_due [8];
   int          u_hd, u_tl;
   logic [31:0] cap_data [64];
   logic [4:0]  cap_dest [64];
   int          wb_cnt = 0;

   always #5 clk = ~clk;

   imuldiv_muldiv_frontend #(.TRACK_DEPTH(2)) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
      .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a), .muldivreq_msg_b(muldivreq_msg_b),
      .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
      .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy),
      .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_data(wb_data), .wb_dest(wb_dest),
      .outstanding(outstanding)
   );

   function automatic logic [63:0] unit_calc(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic signed [63:0] pa, pb;
      sa = a;
      sb = b;
      pa = sa;
      pb = sb;
      if (fn == 3'd0) return pa * pb;
      if (b == 32'd0) return 64'd0;
      if (fn == 3'd1) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
   endfunction

   // pipelined unit model: accepts every cycle, answers LAT cycles later in order
   always_comb begin
      muldivreq_rdy         = (u_tl - u_hd) < 8;
      muldivresp_val        = (u_tl != u_hd) && (cyc >= u_due[u_hd % 8]);
      muldivresp_msg_result = u_res[u_hd % 8];
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         u_hd <= 0;
         u_tl <= 0;
      end else begin
         if (muldivresp_val && muldivresp_rdy) u_hd <= u_hd + 1;
         if (muldivreq_val && muldivreq_rdy) begin
            u_res[u_tl % 8] <= unit_calc(muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b);
            u_due[u_tl % 8] <= cyc + LAT;
            u_tl <= u_tl + 1;
         end
      end
   end

   always @(negedge clk)
      if (!reset && wb_val && wb_rdy && wb_cnt < 64) begin
         cap_data[wb_cnt] <= wb_data;
         cap_dest[wb_cnt] <= wb_dest;
         wb_cnt <= wb_cnt + 1;
      end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d, output logic saw);
      int k = 0;
      req_val  = 1'b1;
      req_op   = op;
      req_a    = a;
      req_b    = b;
      req_dest = d;
      @(negedge clk);
      while (!req_rdy && k < 200) begin
         @(negedge clk);
         k++;
      end
      saw = muldivreq_val;
      tests++;
      if (req_rdy !== 1'b1) begin
         fails++;
         $display("FAIL issue_timeout op=%0d dest=%0d: req_rdy=%b, required 1", op, d, req_rdy);
      end
      @(posedge clk);
      #1 req_val = 1'b0;
   endtask

   task automatic wait_wb(input int n);
      int k = 0;
      while (wb_cnt < n && k < 300) begin
         @(posedge clk);
         k++;
      end
      #1;
      tests++;
      if (wb_cnt < n) begin
         fails++;
         $display("FAIL wait_wb: got %0d writebacks, required %0d", wb_cnt, n);
      end
   endtask

   task automatic test_reset;
      reset   = 1'b1;
      req_val = 1'b1;
      req_op  = 3'd0;
      req_a   = 32'd1;
      req_b   = 32'd1;
      req_dest = 5'd1;
      wb_rdy  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({req_rdy, muldivreq_val, muldivresp_rdy} !== 3'b000) begin
         fails++;
         $display("FAIL reset_handshakes: req_rdy/muldivreq_val/muldivresp_rdy=%b, required 000", {req_rdy, muldivreq_val, muldivresp_rdy});
      end
      tests++;
      if (wb_val !== 1'b0 || wb_data !== 32'd0 || wb_dest !== 5'd0 || outstanding !== 2'd0) begin
         fails++;
         $display("FAIL reset_state: wb_val=%b wb_data=%h wb_dest=%0d outstanding=%0d, required 0 0 0 0", wb_val, wb_data, wb_dest, outstanding);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      req_val = 1'b0;
   endtask

   task automatic test_mul;
      logic s;
      int b = wb_cnt;
      logic [31:0] ed [2] = '{32'hffffffc0, 32'hffffffff};
      logic [4:0]  et [2] = '{5'd3, 5'd4};
      issue(3'd0, 32'hfffffff8, 32'h00000008, 5'd3, s);
      issue(3'd1, 32'hfffffff8, 32'h00000008, 5'd4, s);
      wait_wb(b + 2);
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (cap_data[b+i] !== ed[i] || cap_dest[b+i] !== et[i]) begin
            fails++;
            $display("FAIL mul_wb%0d: data=%h dest=%0d, required data=%h dest=%0d", i, cap_data[b+i], cap_dest[b+i], ed[i], et[i]);
         end
      end
   endtask

   task automatic test_div;
      logic s;
      int b = wb_cnt;
      logic [31:0] ed [3] = '{32'hffffdf75, 32'h00003372, 32'hffffd353};
      logic [4:0]  et [3] = '{5'd5, 5'd6, 5'd7};
      issue(3'd2, 32'h0a01b044, 32'hffffb14a, 5'd5, s);
      issue(3'd3, 32'h0a01b044, 32'hffffb14a, 5'd6, s);
      issue(3'd2, 32'hdeadbeef, 32'h0000beef, 5'd7, s);
      wait_wb(b + 3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[b+i] !== ed[i] || cap_dest[b+i] !== et[i]) begin
            fails++;
            $display("FAIL div_wb%0d: data=%h dest=%0d, required data=%h dest=%0d", i, cap_data[b+i], cap_dest[b+i], ed[i], et[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic s;
      int b = wb_cnt;
      logic [31:0] ed [2] = '{32'h00000004, 32'h02a81526};
      logic [4:0]  et [2] = '{5'd8, 5'd9};
      issue(3'd4, 32'h799b39de, 32'h1dbcc92e, 5'd8, s);
      issue(3'd5, 32'h799b39de, 32'h1dbcc92e, 5'd9, s);
      wait_wb(b + 2);
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (cap_data[b+i] !== ed[i] || cap_dest[b+i] !== et[i]) begin
            fails++;
            $display("FAIL b2b_wb%0d: data=%h dest=%0d, required data=%h dest=%0d", i, cap_data[b+i], cap_dest[b+i], ed[i], et[i]);
         end
      end
   endtask

   task automatic test_bypass_latency;
      logic s;
      int b = wb_cnt;
      issue(3'd7, 32'd5, 32'd5, 5'd17, s);
      @(negedge clk);
      tests++;
      if (wb_val !== 1'b1 || wb_data !== 32'd0 || wb_dest !== 5'd17 || outstanding !== 2'd0) begin
         fails++;
         $display("FAIL bypass_latency: wb_val=%b data=%h dest=%0d outstanding=%0d, required 1 00000000 17 0", wb_val, wb_data, wb_dest, outstanding);
      end
      wait_wb(b + 1);
   endtask

   task automatic test_backpressure;
      logic s;
      int k = 0;
      int b = wb_cnt;
      logic [31:0] ed [3] = '{32'd6, 32'd20, 32'd49};
      logic [4:0]  et [3] = '{5'd1, 5'd2, 5'd4};
      wb_rdy = 1'b0;
      issue(3'd0, 32'd2, 32'd3, 5'd1, s);
      issue(3'd0, 32'd4, 32'd5, 5'd2, s);
      req_val  = 1'b1;
      req_op   = 3'd0;
      req_a    = 32'd7;
      req_b    = 32'd7;
      req_dest = 5'd4;
      @(negedge clk);
      tests++;
      if (req_rdy !== 1'b0 || outstanding !== 2'd2) begin
         fails++;
         $display("FAIL bp_full: req_rdy=%b outstanding=%0d, required 0 2", req_rdy, outstanding);
      end
      while (!req_rdy && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      #1 req_val = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      tests++;
      if (wb_val !== 1'b1 || wb_data !== 32'd6 || wb_dest !== 5'd1 || outstanding !== 2'd2) begin
         fails++;
         $display("FAIL bp_hold: wb_val=%b data=%h dest=%0d outstanding=%0d, required 1 00000006 1 2", wb_val, wb_data, wb_dest, outstanding);
      end
      @(posedge clk);
      #1 wb_rdy = 1'b1;
      wait_wb(b + 3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[b+i] !== ed[i] || cap_dest[b+i] !== et[i]) begin
            fails++;
            $display("FAIL bp_wb%0d: data=%h dest=%0d, required data=%h dest=%0d", i, cap_data[b+i], cap_dest[b+i], ed[i], et[i]);
         end
      end
   endtask

   task automatic test_illegal;
      logic s;
      int b = wb_cnt;
      logic [31:0] ed [3] = '{32'h00000018, 32'h00000000, 32'h0000000d};
      logic [4:0]  et [3] = '{5'd10, 5'd9, 5'd11};
      issue(3'd0, 32'd8, 32'd3, 5'd10, s);
      issue(3'd6, 32'h12345678, 32'h9abcdef0, 5'd9, s);
      tests++;
      if (s !== 1'b0) begin
         fails++;
         $display("FAIL illegal_reqval: muldivreq_val=%b, required 0", s);
      end
      issue(3'd2, 32'h222, 32'h2a, 5'd11, s);
      wait_wb(b + 3);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (cap_data[b+i] !== ed[i] || cap_dest[b+i] !== et[i]) begin
            fails++;
            $display("FAIL illegal_wb%0d: data=%h dest=%0d, required data=%h dest=%0d", i, cap_data[b+i], cap_dest[b+i], ed[i], et[i]);
         end
      end
   endtask

   task automatic test_reset_inflight;
      logic s;
      int b = wb_cnt;
      issue(3'd2, 32'd100, 32'd7, 5'd12, s);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      tests++;
      if (wb_val !== 1'b0 || outstanding !== 2'd0) begin
         fails++;
         $display("FAIL rst_flight: wb_val=%b outstanding=%0d, required 0 0", wb_val, outstanding);
      end
      repeat (LAT + 6) @(posedge clk);
      #1;
      tests++;
      if (wb_cnt !== b) begin
         fails++;
         $display("FAIL rst_stale: writebacks=%0d, required %0d", wb_cnt, b);
      end
      issue(3'd0, 32'd1, 32'd1, 5'd13, s);
      wait_wb(b + 1);
      tests++;
      if (cap_data[b] !== 32'd1 || cap_dest[b] !== 5'd13) begin
         fails++;
         $display("FAIL rst_next: data=%h dest=%0d, required data=00000001 dest=13", cap_data[b], cap_dest[b]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_back_to_back();
      test_bypass_latency();
      test_backpressure();
      test_illegal();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/imuldiv_muldiv_frontend.md
# imuldiv_muldiv_frontend

Processor-facing front end for the iterative integer mul/div unit. It decodes a 3-bit processor op into the unit's function code, forwards operands over the unit's val/rdy request interface, and tracks outstanding ops in a small in-order FIFO. It consumes the unit's 64-bit result and selects the 32-bit half the op asks for. It returns the selected half with the destination register index on a registered val/rdy writeback port.

## Interface
- TRACK_DEPTH, 2: outstanding-op tracking FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- req_val / req_rdy  in / out  1 / 1  processor request handshake
- req_op  in  3  0 MUL, 1 MULH, 2 DIV, 3 REM, 4 DIVU, 5 REMU, 6–7 illegal
- req_a, req_b  in  32 each  operands
- req_dest  in  5  destination register index
- muldivreq_msg_fn  out  3  to unit: 0 mul, 1 div/rem signed, 2 divu/remu
- muldivreq_msg_a, muldivreq_msg_b  out  32 each  operands to unit (pass-through of req_a/req_b)
- muldivreq_val / muldivreq_rdy  out / in  1 / 1  unit request handshake
- muldivresp_msg_result  in  64  unit result: {hi, lo}; mul = full product, div = {rem, quot}
- muldivresp_val / muldivresp_rdy  in / out  1 / 1  unit response handshake
- wb_val / wb_rdy  out / in  1 / 1  writeback handshake
- wb_data  out  32  selected result
- wb_dest  out  5  destination of wb_data
- outstanding  out  $clog2(TRACK_DEPTH)+1  tracking FIFO occupancy

## Operation
- Decode: MUL→fn0/lo, MULH→fn0/hi, DIV→fn1/lo, REM→fn1/hi, DIVU→fn2/lo, REMU→fn2/hi. Ops 6–7 are illegal and are marked bypass.
- Request path is combinational:
  - full = (outstanding == TRACK_DEPTH).
  - Legal op: muldivreq_val = req_val && !full; req_rdy = muldivreq_rdy && !full.
  - Illegal op: muldivreq_val = 0; req_rdy = !full.
- Request fire (req_val && req_rdy): push {hi_sel, bypass, dest} into the tracking FIFO.
- Response consumption (head entry valid, out_free = !wb_val || wb_rdy):
  - Head not bypass: muldivresp_rdy = out_free. On fire, load wb_data = hi_sel ? result[63:32] : result[31:0], load wb_dest = head.dest, set wb_val, pop.
  - Head bypass: muldivresp_rdy = 0. When out_free, load wb_data = 0, load wb_dest = head.dest, set wb_val, pop. No response is consumed.
  - FIFO empty: muldivresp_rdy = 0.
- Writeback register: wb_val clears on wb_val && wb_rdy when no new load happens in the same cycle. A load and a drain in the same cycle replaces the register contents, with no bubble.
- FIFO rules:
  - Push and pop in the same cycle leave outstanding unchanged.
  - Pointers wrap modulo TRACK_DEPTH.
  - req_rdy uses the registered full flag only. A pop in the same cycle does not grant a push.
- Writebacks leave in request order. The unit is in-order, so no tags are needed.
- Reset:
  - Empties the FIFO and sets outstanding = 0.
  - Sets wb_val = 0, wb_data = 0, wb_dest = 0.
  - Forces req_rdy, muldivreq_val and muldivresp_rdy to 0 while reset is high.
  - The unit shares the same reset, so in-flight ops are discarded on both sides.

## Timing
- Request accepted at cycle t. Unit response fires at cycle r > t. wb_val is high from cycle r+1.
- Bypass op accepted at cycle t into an empty FIFO with a free output register: wb_val is high at t+1.
- wb_data and wb_dest stay stable while wb_val && !wb_rdy.
- At most one writeback load per cycle. Sustained throughput is limited by the unit, not the front end.
- There is no combinational path from wb_rdy to req_rdy. There is a combinational path from wb_rdy to muldivresp_rdy.

## Test plan
- MUL a=fffffff8 b=00000008, dest 3 → wb_data ffffffc0, wb_dest 3. MULH with the same operands → ffffffff.
- DIV a=0a01b044 b=ffffb14a → ffffdf75. REM with the same operands → 00003372. DIV a=deadbeef b=0000beef → ffffd353.
- DIVU a=799b39de b=1dbcc92e → 00000004. REMU with the same operands → 02a81526. Back-to-back issue; results return in order.
- Backpressure: hold wb_rdy=0 and issue 3 MULs.
  - Exactly 2 are accepted; outstanding=2 and req_rdy=0 for the third.
  - wb stays stable showing the first result.
  - Releasing wb_rdy drains all three in order.
- Illegal op 6, dest 9, issued between MUL 8×3 and DIV 222/2a → writebacks 00000018, then 0 (dest 9), then 0000000d. muldivreq_val stays 0 for the illegal op.
- Assert reset for 1 cycle while a DIV is in flight → wb_val=0, outstanding=0, no stale writeback. The next MUL 1×1 → 00000001.
